// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared constants and FSM encoding for the instruction fetch unit
package if_fetch_unit_pkg;

    localparam logic [15:0] NOP_INSTR = 16'h0000;
    localparam logic [15:0] PC_INC    = 16'd2;

    localparam logic [1:0] ST_BOOT    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    // Wraps modulo 2^16 by construction of the 16-bit result.
    function automatic logic [15:0] pc_next(input logic [15:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: drives imem requests, holds a stalled word,
// and squashes in-flight responses on redirect.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_ID,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr_IF,
    output logic [15:0] pc_IF
);

    logic [1:0]  state_q, state_d;
    logic [15:0] pc_r, pc_d;
    logic [15:0] tgt_r, tgt_d;
    logic [15:0] buf_instr, buf_instr_d;
    logic [15:0] buf_pc, buf_pc_d;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_r;
        tgt_d       = tgt_r;
        buf_instr_d = buf_instr;
        buf_pc_d    = buf_pc;
        imem_req    = 1'b0;
        instr_IF    = NOP_INSTR;
        pc_IF       = pc_r;

        case (state_q)
            ST_BOOT: begin
                if (redirect_valid) pc_d = redirect_pc;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (redirect_valid) begin
                    // A response landing with the redirect is simply dropped; otherwise the
                    // outstanding request must still complete before the target is fetched.
                    if (imem_ready) begin
                        pc_d = redirect_pc;
                    end else begin
                        tgt_d   = redirect_pc;
                        state_d = ST_DISCARD;
                    end
                end else if (imem_ready) begin
                    instr_IF = imem_rdata;
                    pc_d     = pc_next(pc_r);
                    if (stall_ID) begin
                        buf_instr_d = imem_rdata;
                        buf_pc_d    = pc_r;
                        state_d     = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                pc_IF = buf_pc;
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = ST_FETCH;
                end else begin
                    instr_IF = buf_instr;
                    if (!stall_ID) state_d = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    pc_d    = redirect_valid ? redirect_pc : tgt_r;
                    state_d = ST_FETCH;
                end else if (redirect_valid) begin
                    tgt_d = redirect_pc;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    assign imem_addr = pc_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_BOOT;
            pc_r      <= RESET_PC;
            tgt_r     <= 16'h0000;
            buf_instr <= 16'h0000;
            buf_pc    <= 16'h0000;
        end else begin
            state_q   <= state_d;
            pc_r      <= pc_d;
            tgt_r     <= tgt_d;
            buf_instr <= buf_instr_d;
            buf_pc    <= buf_pc_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed vector table plus randomized run against a stream-level model
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_ID;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [15:0] instr_IF;
    logic [15:0] pc_IF;

    int n_cmp = 0;
    int n_err = 0;

    if_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_ID      (stall_ID),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr_IF      (instr_IF),
        .pc_IF         (pc_IF)
    );

    always #5 clk = ~clk;

    // Memory contents: never zero, so a real word is always distinguishable from NOP.
    function automatic logic [15:0] word(input logic [15:0] a);
        return (a ^ 16'h3C00) | 16'h0001;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        stall;
        logic        rv;
        logic [15:0] rpc;
        logic        rdy;
        logic [15:0] rdata;
        logic        ereq;
        logic [15:0] eaddr;
        logic [15:0] einstr;
        logic [15:0] epc;
        logic        chkpc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic stall, input logic rv, input logic [15:0] rpc,
                       input logic rdy, input logic [15:0] rdata, input logic ereq,
                       input logic [15:0] eaddr, input logic [15:0] einstr,
                       input logic [15:0] epc, input logic chkpc);
        vec_t v;
        v.rst = rst; v.stall = stall; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.rdata = rdata;
        v.ereq = ereq; v.eaddr = eaddr; v.einstr = einstr; v.epc = epc; v.chkpc = chkpc;
        vecs.push_back(v);
    endtask

    // stream-level reference state for the random run
    logic [15:0] exp_pc;
    logic        held;
    logic [15:0] h_instr, h_pc;
    logic        outstanding;
    logic [15:0] out_addr;
    int          lat, cnt, accepts;
    logic [15:0] tgt;

    initial begin
        rst_n = 1'b0; stall_ID = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
        imem_ready = 1'b0; imem_rdata = 16'h0;

        // reset, zero-wait stream
        add(0,0,0,16'h0,   0,16'h0,        0,16'h0000,16'h0,         16'h0000,1);
        add(1,0,0,16'h0,   0,16'h0,        0,16'h0000,16'h0,         16'h0000,1);
        add(1,0,0,16'h0,   1,word(16'h0),  1,16'h0000,word(16'h0),   16'h0000,1);
        add(1,0,0,16'h0,   1,word(16'h2),  1,16'h0002,word(16'h2),   16'h0002,1);
        add(1,0,0,16'h0,   1,word(16'h4),  1,16'h0004,word(16'h4),   16'h0004,1);
        add(1,0,0,16'h0,   1,word(16'h6),  1,16'h0006,word(16'h6),   16'h0006,1);
        // two wait cycles
        add(1,0,0,16'h0,   0,16'hDEAD,     1,16'h0008,16'h0,         16'h0008,1);
        add(1,0,0,16'h0,   0,16'hBEEF,     1,16'h0008,16'h0,         16'h0008,1);
        add(1,0,0,16'h0,   1,word(16'h8),  1,16'h0008,word(16'h8),   16'h0008,1);
        // stall for three cycles then release
        add(1,1,0,16'h0,   1,word(16'hA),  1,16'h000A,word(16'hA),   16'h000A,1);
        add(1,1,0,16'h0,   0,16'h1234,     0,16'h000C,word(16'hA),   16'h000A,1);
        add(1,1,0,16'h0,   0,16'h1234,     0,16'h000C,word(16'hA),   16'h000A,1);
        add(1,0,0,16'h0,   0,16'h1234,     0,16'h000C,word(16'hA),   16'h000A,1);
        add(1,0,0,16'h0,   1,word(16'hC),  1,16'h000C,word(16'hC),   16'h000C,1);
        // redirect while a three-cycle request is outstanding
        add(1,0,0,16'h0,   0,16'h5555,     1,16'h000E,16'h0,         16'h000E,1);
        add(1,0,1,16'h0100,0,16'h5555,     1,16'h000E,16'h0,         16'h000E,1);
        add(1,0,0,16'h0,   0,16'h5555,     1,16'h000E,16'h0,         16'h000E,1);
        add(1,0,0,16'h0,   1,word(16'hE),  1,16'h000E,16'h0,         16'h000E,1);
        add(1,0,0,16'h0,   1,word(16'h100),1,16'h0100,word(16'h100), 16'h0100,1);
        // redirect in HOLD while stalled
        add(1,1,0,16'h0,   1,word(16'h102),1,16'h0102,word(16'h102), 16'h0102,1);
        add(1,1,1,16'h0200,0,16'h7777,     0,16'h0104,16'h0,         16'h0000,0);
        add(1,0,0,16'h0,   1,word(16'h200),1,16'h0200,word(16'h200), 16'h0200,1);
        // redirect with ready to the top of the address space, then wrap
        add(1,0,1,16'hFFFE,1,word(16'h202),1,16'h0202,16'h0,         16'h0202,1);
        add(1,0,0,16'h0,   1,word(16'hFFFE),1,16'hFFFE,word(16'hFFFE),16'hFFFE,1);
        add(1,0,0,16'h0,   0,16'h9999,     1,16'h0000,16'h0,         16'h0000,1);
        add(1,0,0,16'h0,   1,word(16'h0),  1,16'h0000,word(16'h0),   16'h0000,1);
        // reset mid-request; the response arriving under reset is never consumed
        add(1,0,0,16'h0,   0,16'h9999,     1,16'h0002,16'h0,         16'h0002,1);
        add(0,0,0,16'h0,   1,word(16'h2),  0,16'h0000,16'h0,         16'h0000,1);
        add(1,0,0,16'h0,   0,16'h0,        0,16'h0000,16'h0,         16'h0000,1);
        add(1,0,0,16'h0,   1,word(16'h0),  1,16'h0000,word(16'h0),   16'h0000,1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            rst_n          = vecs[i].rst;
            stall_ID       = vecs[i].stall;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            imem_ready     = vecs[i].rdy;
            imem_rdata     = vecs[i].rdata;
            #4;
            check($sformatf("v%0d_req", i),   {31'd0, imem_req}, {31'd0, vecs[i].ereq});
            check($sformatf("v%0d_addr", i),  {16'd0, imem_addr}, {16'd0, vecs[i].eaddr});
            check($sformatf("v%0d_instr", i), {16'd0, instr_IF}, {16'd0, vecs[i].einstr});
            if (vecs[i].chkpc)
                check($sformatf("v%0d_pc", i), {16'd0, pc_IF}, {16'd0, vecs[i].epc});
        end

        // randomized run
        @(posedge clk); #1;
        rst_n = 1'b0; stall_ID = 1'b0; redirect_valid = 1'b0; imem_ready = 1'b0;
        exp_pc = 16'h0000; held = 1'b0; outstanding = 1'b0; accepts = 0; lat = 0; cnt = 0;
        out_addr = 16'h0; h_instr = 16'h0; h_pc = 16'h0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0; stall_ID = 1'b0; redirect_valid = 1'b0;
                imem_ready = 1'b0; imem_rdata = 16'($urandom);
                outstanding = 1'b0; held = 1'b0; exp_pc = 16'h0000;
                #4;
                check("rst_req",   {31'd0, imem_req}, 32'd0);
                check("rst_instr", {16'd0, instr_IF}, 32'd0);
                check("rst_pc",    {16'd0, pc_IF},    32'd0);
                continue;
            end
            rst_n = 1'b1;
            if (outstanding)
                check("proto_addr_hold", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, out_addr});
            if (imem_req && !outstanding) begin
                outstanding = 1'b1;
                out_addr    = imem_addr;
                lat         = $urandom_range(0, 3);
                cnt         = 0;
            end
            imem_ready = outstanding && (cnt == lat);
            imem_rdata = imem_ready ? word(imem_addr) : 16'($urandom);
            stall_ID   = ($urandom_range(0, 2) == 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            tgt = 16'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 3) == 0) tgt = 16'hFFF8 | (tgt & 16'h0006);
            redirect_pc = tgt;
            #4;
            if (redirect_valid) begin
                check("redir_nop", {16'd0, instr_IF}, 32'd0);
                exp_pc = redirect_pc;
                held   = 1'b0;
            end else if (instr_IF != 16'h0000) begin
                check("seq_pc",   {16'd0, pc_IF},    {16'd0, exp_pc});
                check("seq_word", {16'd0, instr_IF}, {16'd0, word(pc_IF)});
                if (held)
                    check("hold_stable", {instr_IF, pc_IF}, {h_instr, h_pc});
                if (!stall_ID) begin
                    accepts++;
                    exp_pc = exp_pc + 16'd2;
                    held   = 1'b0;
                end else begin
                    held    = 1'b1;
                    h_instr = instr_IF;
                    h_pc    = pc_IF;
                end
            end else if (held) begin
                check("hold_dropped", {16'd0, instr_IF}, {16'd0, h_instr});
                held = 1'b0;
            end
            if (imem_ready) outstanding = 1'b0;
            else if (outstanding) cnt++;
        end
        check("liveness_accepts_gt_200", {31'd0, accepts > 200}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 The block SHALL use reset rst_n, asynchronous, active-low, and clock clk.
REQ-002 Port list SHALL be, name / direction / width / meaning:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- stall_ID  in  1  IF/ID register holding this cycle
- redirect_valid  in  1  branch/jump resolved, one-cycle pulse
- redirect_pc  in  16  redirect target
- imem_req  out  1  instruction memory request
- imem_addr  out  16  request address
- imem_ready  in  1  response valid this cycle
- imem_rdata  in  16  instruction word
- instr_IF  out  16  instruction to IF/ID
- pc_IF  out  16  PC of instr_IF
REQ-003 Parameter SHALL be RESET_PC, default 16'h0000, first fetch address.

Function
REQ-004 The FSM SHALL have four states: BOOT, FETCH, HOLD, DISCARD.
REQ-005 Registers SHALL be pc_r (16, outstanding/next fetch address), tgt_r (16, pending redirect target), buf_instr/buf_pc (16 each, held instruction).
REQ-006 The memory protocol SHALL be: imem_req high with imem_addr stable until the cycle imem_ready=1; imem_rdata is valid in that cycle; zero-wait is legal (ready in the first req cycle).
REQ-007 imem_req SHALL be 1 in FETCH and DISCARD and 0 in BOOT and HOLD; imem_addr SHALL equal pc_r.
REQ-008 BOOT SHALL go to FETCH after one cycle; a redirect in BOOT SHALL load pc_r=redirect_pc.
REQ-009 FETCH, no redirect, imem_ready=1, stall_ID=0: instr_IF=imem_rdata, pc_IF=pc_r, pc_r+=2, stay in FETCH.
REQ-010 FETCH, no redirect, imem_ready=1, stall_ID=1: present the same outputs, capture into buf, pc_r+=2, go to HOLD.
REQ-011 FETCH, imem_ready=0: present NOP with pc_IF=pc_r, stay in FETCH.
REQ-012 FETCH with redirect_valid: present NOP.
- If imem_ready=1, pc_r=redirect_pc and stay in FETCH.
- Otherwise, tgt_r=redirect_pc and go to DISCARD.
REQ-013 HOLD SHALL present buf_instr/buf_pc.
- redirect_valid: pc_r=redirect_pc, present NOP, go to FETCH.
- Else stall_ID=0: go to FETCH.
- Else stay in HOLD.
REQ-014 DISCARD SHALL present NOP and keep the old pc_r on imem_addr.
- imem_ready=1: pc_r=tgt_r (or redirect_pc if a redirect arrives that cycle), go to FETCH.
- A redirect without ready SHALL overwrite tgt_r.
REQ-015 redirect_valid SHALL take priority over stall_ID in every state.
REQ-016 No data from a discarded response or a flushed buf SHALL ever appear on instr_IF.
REQ-017 PC arithmetic SHALL be modulo 2^16: 16'hFFFE+2 gives 16'h0000.
REQ-018 instr_IF and pc_IF SHALL be combinational from state, buf and imem_rdata; they SHALL hold stable while stall_ID=1 in HOLD.

Reset
REQ-019 In reset, state=BOOT, pc_r=RESET_PC, tgt_r=0, buf=0.
REQ-020 Outputs in reset SHALL be imem_req=0, instr_IF=NOP, pc_IF=RESET_PC.
REQ-021 Reset mid-request SHALL abandon the request; the response is never consumed.

Structure
REQ-022 The shared package SHALL hold NOP_INSTR (16'h0000), PC_INC (16'd2) and the FSM state encoding.
REQ-023 The block SHALL be a single module with no sub-module.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Zero-wait memory, no stall, 4 cycles after reset -> pc_IF 0000,0002,0004,0006 with matching words.
- 2-cycle latency -> imem_addr held two cycles; instr_IF shows NOP, NOP, word.
- Ready with stall_ID high for 3 cycles -> HOLD, outputs constant, imem_req=0, then FETCH at pc+2.
- Redirect to 16'h0100 while a 3-cycle request is outstanding -> DISCARD, old word never presented, next imem_addr=0100.
- Redirect in HOLD with stall_ID=1 -> buf dropped, NOP, fetch from redirect_pc.
- pc_r=16'hFFFE fetched -> next imem_addr=16'h0000; rst_n pulsed mid-request -> BOOT, pc_IF=RESET_PC.
